// File: rtl/simple_isa_pkg.sv
// Shared encodings for the simple ISA core: phases, opcodes, sequencer states, fault codes.
package simple_isa_pkg;

    typedef enum logic [1:0] {
        PH_IF = 2'd0,
        PH_ID = 2'd1,
        PH_EX = 2'd2,
        PH_WB = 2'd3
    } phase_e;

    localparam logic [3:0] OP_NOP = 4'd0;
    localparam logic [3:0] OP_LDI = 4'd1;
    localparam logic [3:0] OP_ADD = 4'd2;
    localparam logic [3:0] OP_SUB = 4'd3;
    localparam logic [3:0] OP_AND = 4'd4;
    localparam logic [3:0] OP_OR  = 4'd5;
    localparam logic [3:0] OP_JMP = 4'd8;
    localparam logic [3:0] OP_BRZ = 4'd9;

    typedef logic [2:0] seq_state_e;

    localparam seq_state_e ST_IDLE  = 3'd0;
    localparam seq_state_e ST_FETCH = 3'd1;
    localparam seq_state_e ST_DEC   = 3'd2;
    localparam seq_state_e ST_EXE   = 3'd3;
    localparam seq_state_e ST_WBK   = 3'd4;
    localparam seq_state_e ST_FAULT = 3'd5;

    localparam logic [1:0] FAULT_NONE    = 2'd0;
    localparam logic [1:0] FAULT_ILLEGAL = 2'd1;
    localparam logic [1:0] FAULT_TIMEOUT = 2'd2;

    function automatic logic is_legal_op(input logic [3:0] op);
        logic legal;
        case (op)
            OP_NOP, OP_LDI, OP_ADD, OP_SUB,
            OP_AND, OP_OR, OP_JMP, OP_BRZ: legal = 1'b1;
            default:                       legal = 1'b0;
        endcase
        return legal;
    endfunction

endpackage

// File: rtl/simple_fetch_if.sv
// imem fetch port: holds req until ack, captures legal words, counts unacked wait cycles.
module simple_fetch_if
    import simple_isa_pkg::*;
#(
    parameter int unsigned INSTR_W       = 16,
    parameter int unsigned FETCH_TIMEOUT = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               fetch_en,
    input  logic               ack,
    input  logic [INSTR_W-1:0] rdata,
    output logic               req,
    output logic [INSTR_W-1:0] instr,
    output logic               done_c,
    output logic               illegal_c,
    output logic               timeout_c
);

    localparam int unsigned TO_W = (FETCH_TIMEOUT > 1) ? $clog2(FETCH_TIMEOUT) : 1;

    logic [TO_W-1:0] wait_cnt;
    logic            op_ok_c;

    assign op_ok_c   = is_legal_op(rdata[INSTR_W-1 -: 4]);
    assign done_c    = req & ack & op_ok_c;
    assign illegal_c = req & ack & ~op_ok_c;
    // Timeout fires on the cycle the unacked-wait count reaches FETCH_TIMEOUT.
    assign timeout_c = (FETCH_TIMEOUT != 0) & req & ~ack &
                       (wait_cnt == TO_W'(FETCH_TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            req      <= 1'b0;
            wait_cnt <= '0;
            instr    <= '0;
        end else begin
            req <= fetch_en;
            if (req && !ack && fetch_en) begin
                wait_cnt <= wait_cnt + TO_W'(1);
            end else begin
                wait_cnt <= '0;
            end
            if (done_c) begin
                instr <= rdata;
            end
        end
    end

endmodule

// File: rtl/simple_seq_ctrl.sv
// Instruction sequencer: owns PC, phase FSM, run/step/breakpoint control and fault reporting.
module simple_seq_ctrl
    import simple_isa_pkg::*;
#(
    parameter int unsigned PC_W          = 8,
    parameter int unsigned INSTR_W       = 16,
    parameter int unsigned CNT_W         = 16,
    parameter int unsigned FETCH_TIMEOUT = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               run,
    input  logic               step,
    input  logic               bp_en,
    input  logic [PC_W-1:0]    bp_addr,
    input  logic               fault_clr,
    output logic               imem_req,
    output logic [PC_W-1:0]    imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic [PC_W-1:0]    pc_incr,
    output logic [1:0]         phase,
    output logic [INSTR_W-1:0] instr,
    output logic [PC_W-1:0]    pc,
    output logic               halted,
    output logic               bp_hit,
    output logic [1:0]         fault,
    output logic [CNT_W-1:0]   retired
);

    seq_state_e      state, state_next;
    phase_e          phase_next;
    logic            halted_next;
    logic            bp_hit_next;
    logic [1:0]      fault_next;
    logic            run_q, step_q, bp_skip;
    logic            rise_c, fetch_entry_c;
    logic            bp_at_pc_c, bp_at_next_c;
    logic [PC_W-1:0] pc_sum_c;
    logic            done_c, illegal_c, timeout_c;

    assign rise_c       = (run & ~run_q) | (step & ~step_q);
    assign pc_sum_c     = pc + pc_incr;
    assign bp_at_pc_c   = bp_en & (pc == bp_addr);
    assign bp_at_next_c = bp_en & (pc_sum_c == bp_addr);
    assign imem_addr    = pc;
    assign fetch_entry_c = (state_next == ST_FETCH) && (state != ST_FETCH);

    simple_fetch_if #(
        .INSTR_W       (INSTR_W),
        .FETCH_TIMEOUT (FETCH_TIMEOUT)
    ) u_fetch (
        .clk       (clk),
        .reset     (reset),
        .fetch_en  (state_next == ST_FETCH),
        .ack       (imem_ack),
        .rdata     (imem_rdata),
        .req       (imem_req),
        .instr     (instr),
        .done_c    (done_c),
        .illegal_c (illegal_c),
        .timeout_c (timeout_c)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        bp_hit_next = bp_hit;
        fault_next  = fault;
        case (state)
            ST_IDLE: begin
                // A fresh run/step edge lets execution leave a breakpointed PC.
                if (run || step) begin
                    if (bp_at_pc_c && !(bp_skip || rise_c)) begin
                        bp_hit_next = 1'b1;
                    end else begin
                        state_next = ST_FETCH;
                    end
                end
            end
            ST_FETCH: begin
                if (illegal_c) begin
                    state_next = ST_FAULT;
                    fault_next = FAULT_ILLEGAL;
                end else if (done_c) begin
                    state_next = ST_DEC;
                end else if (timeout_c) begin
                    state_next = ST_FAULT;
                    fault_next = FAULT_TIMEOUT;
                end
            end
            ST_DEC: state_next = ST_EXE;
            ST_EXE: state_next = ST_WBK;
            ST_WBK: begin
                if (run) begin
                    if (bp_at_next_c) begin
                        state_next  = ST_IDLE;
                        bp_hit_next = 1'b1;
                    end else begin
                        state_next = ST_FETCH;
                    end
                end else begin
                    state_next = ST_IDLE;
                end
            end
            ST_FAULT: begin
                if (fault_clr) begin
                    state_next = ST_IDLE;
                    fault_next = FAULT_NONE;
                end
            end
            default: state_next = ST_IDLE;
        endcase

        if ((state_next == ST_FETCH) && (state != ST_FETCH)) begin
            bp_hit_next = 1'b0;
        end

        case (state_next)
            ST_DEC:  phase_next = PH_ID;
            ST_EXE:  phase_next = PH_EX;
            ST_WBK:  phase_next = PH_WB;
            default: phase_next = PH_IF;
        endcase
        halted_next = (state_next == ST_IDLE) || (state_next == ST_FAULT);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc      <= '0;
            retired <= '0;
            phase   <= PH_IF;
            halted  <= 1'b1;
            bp_hit  <= 1'b0;
            fault   <= FAULT_NONE;
            run_q   <= 1'b0;
            step_q  <= 1'b0;
            bp_skip <= 1'b0;
        end else begin
            if (state == ST_WBK) begin
                pc      <= pc_sum_c;
                retired <= retired + CNT_W'(1);
            end
            phase  <= phase_next;
            halted <= halted_next;
            bp_hit <= bp_hit_next;
            fault  <= fault_next;
            run_q  <= run;
            step_q <= step;
            if (fetch_entry_c) begin
                bp_skip <= 1'b0;
            end else if ((state == ST_IDLE) && rise_c) begin
                bp_skip <= 1'b1;
            end
        end
    end

endmodule
